// File: rtl/sprite_hit_expander.sv
// Expands a 4-bit sprite index into a per-sprite enable vector held for HOLD_FRAMES frames.
// Optional sticky illegal-hit flag (hit_err) is enabled by defining SPRITE_HIT_ERR_EN.
module sprite_hit_expander #(
  parameter int NUM_SPRITES = 14,
  parameter int HOLD_FRAMES = 8,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hit_valid,
  input  logic [3:0]             hit_index,
  input  logic                   frame_tick,
  output logic [NUM_SPRITES-1:0] sprite_en,
  output logic                   active,
`ifdef SPRITE_HIT_ERR_EN
  output logic                   hit_err,
`endif
  output logic [3:0]             newest
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);

  logic [CNT_W-1:0] cnt      [NUM_SPRITES];
  logic [CNT_W-1:0] cnt_next [NUM_SPRITES];
  logic             accept;
  logic             all_idle_next;

  assign accept = hit_valid && (hit_index != 4'd0) &&
                  ({1'b0, hit_index} <= 5'(NUM_SPRITES));

  // A hit on the ticking sprite wins over its decrement; every other sprite still counts down.
  always_comb begin
    all_idle_next = 1'b1;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      cnt_next[i] = cnt[i];
      if (frame_tick && (cnt[i] != '0))
        cnt_next[i] = cnt[i] - CNT_W'(1);
      if (accept && (hit_index == 4'(i + 1)))
        cnt_next[i] = HOLD;
      if (cnt_next[i] != '0)
        all_idle_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++)
        cnt[i] <= cnt_next[i];
    end
  end

  // newest survives expiry of its own sprite and only clears once everything is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      newest <= 4'd0;
    else if (accept)
      newest <= hit_index;
    else if (all_idle_next)
      newest <= 4'd0;
  end

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++)
      sprite_en[i] = (cnt[i] != '0);
  end

  assign active = |sprite_en;

`ifdef SPRITE_HIT_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hit_err <= 1'b0;
    else if (hit_valid && !accept)
      hit_err <= 1'b1;
  end
`endif

endmodule
